// File: rtl/ahb_arb_if.sv
// Bus-side signal bundle for the AHB-Lite arbiter.
// The masters side drives requests and bus status. The arbiter side returns the grant and ownership.
interface ahb_arb_if #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = $clog2(NUM_MASTERS)
);
   // Handshake: an address phase is accepted only on a rising edge with HREADY=1.
   // HREADY=0 stalls the bus, so no accepted-transfer state may advance on that edge.
   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic [1:0]             HTRANS;
   logic [2:0]             HBURST;
   logic                   HREADY;
   logic [1:0]             HRESP;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [MW-1:0]          HMASTER;
   logic                   HMASTLOCK;

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
      input  HGRANT, HMASTER, HMASTLOCK
   );

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
      output HGRANT, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_arbiter.sv
// Registered round-robin AHB-Lite arbiter that protects fixed-length bursts and locked sequences.
// The FSM state and the remaining-beat counter are brought out as debug outputs.
module ahb_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int MW             = $clog2(NUM_MASTERS)
) (
   input  logic       HCLK,
   input  logic       HRESETn,
   ahb_arb_if.slave   bus,
   output logic [1:0] dbg_state,
   output logic [3:0] dbg_rem
);
   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;
   localparam logic [1:0] RESP_OKAY = 2'd0;
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);

   typedef enum logic [1:0] {PARK = 2'd0, OWN = 2'd1, LOCK = 2'd2} state_t;

   state_t                 state, state_next;
   logic [3:0]             rem, rem_next, burst_rem;
   logic [NUM_MASTERS-1:0] grant, grant_next;
   logic [MW-1:0]          last, last_next, grant_idx, master, winner, cand;
   logic                   mastlock, arb_en, any_req, owner_lock;
   int                     rr_idx;

   always_comb begin
      case (bus.HBURST)
         3'd2, 3'd3: burst_rem = 4'd3;
         3'd4, 3'd5: burst_rem = 4'd7;
         3'd6, 3'd7: burst_rem = 4'd15;
         default:    burst_rem = 4'd0;
      endcase
   end

   always_comb begin
      grant_idx = DEF_IDX;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (grant[i]) grant_idx = MW'(i);
   end

   assign owner_lock = bus.HLOCK[grant_idx];

   // A slave error during a wait state ends the burst early, so the next accepted edge may re-arbitrate.
   always_comb begin
      rem_next = rem;
      if (bus.HREADY) begin
         case (bus.HTRANS)
            TR_NONSEQ: rem_next = burst_rem;
            TR_SEQ:    rem_next = (rem == 4'd0) ? 4'd0 : rem - 4'd1;
            TR_IDLE:   rem_next = 4'd0;
            default:   rem_next = rem;
         endcase
      end else if (bus.HRESP != RESP_OKAY) begin
         rem_next = 4'd0;
      end
   end

   assign arb_en = bus.HREADY && (rem_next <= 4'd1) && !owner_lock;

   // The search starts one past the last winner and wraps, so the sole requester re-wins its own slot.
   always_comb begin
      winner  = DEF_IDX;
      any_req = 1'b0;
      rr_idx  = 0;
      cand    = DEF_IDX;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         rr_idx = (int'(last) + i) % NUM_MASTERS;
         cand   = MW'(rr_idx);
         if (!any_req && bus.HBUSREQ[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      grant_next = grant;
      last_next  = last;
      if (arb_en) begin
         if (any_req) begin
            grant_next = NUM_MASTERS'(1) << winner;
            last_next  = winner;
            state_next = bus.HLOCK[winner] ? LOCK : OWN;
         end else begin
            grant_next = DEF_GRANT;
            last_next  = DEF_IDX;
            state_next = PARK;
         end
      end else if (bus.HREADY && owner_lock) begin
         state_next = LOCK;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= PARK;
         grant    <= DEF_GRANT;
         last     <= DEF_IDX;
         master   <= DEF_IDX;
         mastlock <= 1'b0;
         rem      <= 4'd0;
      end else begin
         rem <= rem_next;
         if (bus.HREADY) begin
            state    <= state_next;
            grant    <= grant_next;
            last     <= last_next;
            master   <= grant_idx;
            mastlock <= owner_lock;
         end
      end
   end

   assign bus.HGRANT    = grant;
   assign bus.HMASTER   = master;
   assign bus.HMASTLOCK = mastlock;
   assign dbg_state     = state;
   assign dbg_rem       = rem;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed testbench for ahb_arbiter: rotation, burst protection, wait states, lock, error and reset.
module tb_ahb_arbiter;
   localparam int N = 4;
   localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;
   localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;
   localparam logic [1:0] OKAY = 2'd0, ERROR = 2'd1;
   localparam logic [1:0] S_PARK = 2'd0, S_OWN = 2'd1, S_LOCK = 2'd2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] dbg_state;
   logic [3:0] dbg_rem;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   ahb_arb_if #(.NUM_MASTERS(N)) bus();

   ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
      .HCLK      (clk),
      .HRESETn   (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_rem   (dbg_rem)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                        input logic [2:0] burst, input logic ready, input logic [1:0] resp);
      bus.HBUSREQ = req;
      bus.HLOCK   = lock;
      bus.HTRANS  = trans;
      bus.HBURST  = burst;
      bus.HREADY  = ready;
      bus.HRESP   = resp;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"},    32'(bus.HGRANT),    32'h1);
      check({tag, "_master"},   32'(bus.HMASTER),   32'h0);
      check({tag, "_mastlock"}, 32'(bus.HMASTLOCK), 32'h0);
      check({tag, "_rem"},      32'(dbg_rem),       32'h0);
      check({tag, "_state"},    32'(dbg_state),     32'(S_PARK));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic async_reset_check(input string tag);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic grant_master1();
      drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
      tick();
      check("own1_grant", 32'(bus.HGRANT), 32'h2);
   endtask

   initial begin
      int rot_m[5] = '{0, 1, 2, 3, 0};
      logic [31:0] g;

      do_reset();

      // parking with no requesters
      tick();
      check("park_grant", 32'(bus.HGRANT), 32'h1);
      check("park_state", 32'(dbg_state), 32'(S_PARK));

      // round-robin rotation with all masters requesting single transfers
      drive(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY);
      exp_q.push_back(32'h2);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h2);
      for (int i = 0; i < 5; i++) begin
         tick();
         g = exp_q.pop_front();
         check($sformatf("rot_grant%0d", i), 32'(bus.HGRANT), g);
         check($sformatf("rot_master%0d", i), 32'(bus.HMASTER), 32'(rot_m[i]));
      end

      // lone requester keeps the grant indefinitely
      drive(4'b0100, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("hold_grant%0d", i), 32'(bus.HGRANT), 32'h4);
      end
      check("hold_state", 32'(dbg_state), 32'(S_OWN));
      check("hold_master", 32'(bus.HMASTER), 32'h2);

      // INCR4 handover on the third accepted beat
      do_reset();
      grant_master1();
      drive(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1, OKAY);
      tick();
      check("i4_b1_rem", 32'(dbg_rem), 32'd3);
      check("i4_b1_grant", 32'(bus.HGRANT), 32'h2);
      check("i4_b1_master", 32'(bus.HMASTER), 32'h1);
      drive(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
      tick();
      check("i4_b2_rem", 32'(dbg_rem), 32'd2);
      check("i4_b2_grant", 32'(bus.HGRANT), 32'h2);
      tick();
      check("i4_b3_rem", 32'(dbg_rem), 32'd1);
      check("i4_b3_grant", 32'(bus.HGRANT), 32'h4);
      check("i4_b3_master", 32'(bus.HMASTER), 32'h1);
      drive(4'b0100, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
      tick();
      check("i4_b4_rem", 32'(dbg_rem), 32'd0);
      check("i4_b4_grant", 32'(bus.HGRANT), 32'h4);
      check("i4_b4_master", 32'(bus.HMASTER), 32'h2);

      // INCR4 with three wait states after beat 2
      do_reset();
      grant_master1();
      drive(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1, OKAY);
      tick();
      check("w_rem0", 32'(dbg_rem), 32'd3);
      drive(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
      tick();
      check("w_rem1", 32'(dbg_rem), 32'd2);
      drive(4'b0110, 4'b0000, SEQ, INCR4, 1'b0, OKAY);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("w_wait_rem%0d", i), 32'(dbg_rem), 32'd2);
         check($sformatf("w_wait_grant%0d", i), 32'(bus.HGRANT), 32'h2);
         check($sformatf("w_wait_master%0d", i), 32'(bus.HMASTER), 32'h1);
      end
      drive(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
      tick();
      check("w_rem5", 32'(dbg_rem), 32'd1);
      check("w_grant5", 32'(bus.HGRANT), 32'h4);

      // asynchronous reset mid-burst
      async_reset_check("rst_burst");

      // locked INCR8 from master 3 while others request
      drive(4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, OKAY);
      tick();
      check("lk_grant", 32'(bus.HGRANT), 32'h8);
      check("lk_state", 32'(dbg_state), 32'(S_LOCK));
      drive(4'b1111, 4'b1000, NONSEQ, INCR8, 1'b1, OKAY);
      tick();
      check("lk_b1_rem", 32'(dbg_rem), 32'd7);
      check("lk_b1_master", 32'(bus.HMASTER), 32'h3);
      check("lk_b1_mastlock", 32'(bus.HMASTLOCK), 32'h1);
      drive(4'b1111, 4'b1000, SEQ, INCR8, 1'b1, OKAY);
      for (int i = 0; i < 7; i++) begin
         tick();
         check($sformatf("lk_seq_grant%0d", i), 32'(bus.HGRANT), 32'h8);
         check($sformatf("lk_seq_mastlock%0d", i), 32'(bus.HMASTLOCK), 32'h1);
      end
      check("lk_end_rem", 32'(dbg_rem), 32'd0);
      drive(4'b0111, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
      tick();
      check("lk_rel_grant", 32'(bus.HGRANT), 32'h1);
      check("lk_rel_state", 32'(dbg_state), 32'(S_OWN));
      check("lk_rel_mastlock", 32'(bus.HMASTLOCK), 32'h0);
      check("lk_rel_master", 32'(bus.HMASTER), 32'h3);

      // asynchronous reset mid-lock
      do_reset();
      drive(4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, OKAY);
      tick();
      drive(4'b1000, 4'b1000, NONSEQ, INCR8, 1'b1, OKAY);
      tick();
      check("lk2_mastlock", 32'(bus.HMASTLOCK), 32'h1);
      async_reset_check("rst_lock");

      // INCR16 terminated by an ERROR response after beat 5
      grant_master1();
      drive(4'b0110, 4'b0000, NONSEQ, INCR16, 1'b1, OKAY);
      tick();
      check("er_b1_rem", 32'(dbg_rem), 32'd15);
      drive(4'b0110, 4'b0000, SEQ, INCR16, 1'b1, OKAY);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("er_seq_rem%0d", i), 32'(dbg_rem), 32'(14 - i));
         check($sformatf("er_seq_grant%0d", i), 32'(bus.HGRANT), 32'h2);
      end
      drive(4'b0110, 4'b0000, SEQ, INCR16, 1'b0, ERROR);
      tick();
      check("er_clr_rem", 32'(dbg_rem), 32'd0);
      check("er_clr_grant", 32'(bus.HGRANT), 32'h2);
      drive(4'b0110, 4'b0000, IDLE, SINGLE, 1'b1, ERROR);
      tick();
      check("er_new_grant", 32'(bus.HGRANT), 32'h4);
      check("er_new_master", 32'(bus.HMASTER), 32'h1);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Registered AHB-Lite-style bus arbiter for up to `NUM_MASTERS` masters. It generates `HGRANT`, `HMASTER` and `HMASTLOCK` from per-master `HBUSREQ`/`HLOCK` requests and the shared `HTRANS`/`HBURST`/`HREADY`/`HRESP` bus. Fairness is round-robin, fixed-length bursts are protected, and locked sequences hold the grant. It sits between the masters and the address/control mux, next to the protocol assertions and coverage monitors that watch the same bus.

## Interface

- `NUM_MASTERS`, 4: number of requesting masters, 2..16.
- `DEFAULT_MASTER`, 0: parking master, granted when nobody requests.
- `MW`, `$clog2(NUM_MASTERS)`: width of `HMASTER`.

- `HCLK`  in  1  bus clock, all state on rising edge.
- `HRESETn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `HBUSREQ`  in  NUM_MASTERS  per-master bus request.
- `HLOCK`  in  NUM_MASTERS  per-master locked-access request.
- `HTRANS`  in  2  current address-phase transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `HBURST`  in  3  burst type of current transfer (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- `HREADY`  in  1  transfer-complete / bus-advance.
- `HRESP`  in  2  slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- `HGRANT`  out  NUM_MASTERS  one-hot grant, registered.
- `HMASTER`  out  MW  index of the master owning the address phase, registered.
- `HMASTLOCK`  out  1  current address phase is locked, registered.

## Operation

- Reset values: `HGRANT` one-hot at `DEFAULT_MASTER`; `HMASTER`=`DEFAULT_MASTER`; `HMASTLOCK`=0; beat counter `rem`=0; round-robin pointer `last`=`DEFAULT_MASTER`.
- Beat counter `rem` updates only on edges with `HREADY`=1:
  - NONSEQ: `rem` = burst length − 1 (SINGLE and INCR → 0; x4 → 3; x8 → 7; x16 → 15).
  - SEQ: `rem` = `rem` − 1, saturating at 0.
  - IDLE: `rem` = 0.
  - BUSY: `rem` unchanged.
- Early termination: `HREADY`=0 with `HRESP`≠OKAY (first response cycle) forces `rem`=0.
- Arbitration enable (`arb_en`), evaluated on each edge with `HREADY`=1. It is true when `rem_next`≤1 and the granted master's `HLOCK` is 0. `rem_next` is the value `rem` takes at that edge.
- States:
  - PARK: no requests; grant held at `DEFAULT_MASTER`.
  - OWN: a requester is granted; re-arbitration allowed whenever `arb_en` is true.
  - LOCK: the granted master holds `HLOCK`=1; grant is frozen. Leave LOCK when its `HLOCK`=0 and `arb_en` is true.
- Winner selection when `arb_en` is true:
  - Search requesters from `last`+1 modulo `NUM_MASTERS`; the first asserted `HBUSREQ` wins.
  - If none is asserted, grant `DEFAULT_MASTER` (PARK).
  - The current owner still requesting with no other requester keeps the grant.
  - `last` updates to the winner.
- Requests that drop while ungranted are ignored. A granted master dropping `HBUSREQ` mid-burst keeps the grant until `arb_en`.

## Timing

- `HGRANT` changes only on an `HREADY`=1 edge with `arb_en` true. Decision to visible grant takes 1 cycle.
- `HMASTER` and `HMASTLOCK` load on every `HREADY`=1 edge:
  - `HMASTER` ← index of `HGRANT`.
  - `HMASTLOCK` ← `HLOCK[index]`.
  - Ownership therefore follows the grant by one accepted transfer.
- Wait states: `HREADY`=0 freezes `HGRANT`, `HMASTER`, `HMASTLOCK`, `rem` and `last`. The only exception is the error clear of `rem`.
- Burst handover: for INCR4, the grant moves when the 3rd beat is accepted (`rem_next`=1). The new master drives the address phase immediately after the 4th beat's address phase, with no dead cycle.
- Asynchronous reset mid-burst or mid-lock returns all outputs to their reset values immediately. The first arbitration happens on the first `HREADY`=1 edge after release.
- A single master requesting every cycle with SINGLE transfers keeps the grant indefinitely.

## Test plan

- Reset → `HGRANT`=0001, `HMASTER`=0, `HMASTLOCK`=0 while `HRESETn`=0. Assert `HRESETn` low mid-burst → same values within the same cycle.
- `HBUSREQ`=1111 held, SINGLE NONSEQ every cycle, `HREADY`=1 → grant rotates 0010, 0100, 1000, 0001. `HMASTER` lags `HGRANT` by one cycle.
- Master 1 issues INCR4 (NONSEQ, SEQ×3) with master 2 requesting → `HGRANT` stays 0010 until the 3rd beat is accepted, then becomes 0100. `HMASTER` becomes 2 after the 4th beat.
- Same INCR4 with `HREADY`=0 for 3 cycles on beat 2 → grant handover delayed exactly 3 cycles; `rem` sequence 3, 2, 2, 2, 2, 1.
- Master 3 asserts `HLOCK` with an INCR8 while others request → `HGRANT` fixed at 1000 and `HMASTLOCK`=1 throughout. After `HLOCK` drops, the grant moves to master 0.
- Master 1 INCR16; after beat 5 the slave returns ERROR (`HREADY`=0, `HRESP`=1) → `rem`=0 and master 2 is granted on the next `HREADY`=1 edge.
